// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, the IF/ID record and the
// two-word instruction test.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_IMM  = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD = 16'h4000;

  typedef struct packed {
    logic        valid;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [31:0] pc_plus_one;
  } if_id_t;

  // A cleared fetch word must never open a two-word sequence, whatever IMM_BIT is.
  function automatic logic is_two_word(input logic [15:0] word, input logic [15:0] imm_mask);
    return (word != NOP_WORD) && ((word & imm_mask) != 16'h0);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears it, hold keeps it, load captures d.
// Flush beats hold so a redirect always kills the latched instruction.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!hold && load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage PC/NOP sequencer and IF/ID register (boot, two-word, stall, branch).
// Optional interrupt entry is compiled in when FETCH_CTRL_INT_EN is defined.
module fetch_control
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'd32,
`ifdef FETCH_CTRL_INT_EN
  parameter logic [31:0] INT_VECTOR = 32'd0,
`endif
  parameter int          IMM_BIT    = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  instruction,
  input  logic [15:0]  immediate_value,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
`ifdef FETCH_CTRL_INT_EN
  input  logic         int_req,
  output logic         int_ack,
  output logic [31:0]  int_return_pc,
`endif
  output logic         pc_write,
  output logic [31:0]  pc_write_back_value,
  output logic         clear_instruction,
  output logic         if_id_valid,
  output logic [15:0]  if_id_instruction,
  output logic [15:0]  if_id_immediate,
  output logic [31:0]  if_id_pc_plus_one,
  output fetch_state_t state_dbg
);

  localparam logic [15:0] IMM_MASK = 16'(1) << IMM_BIT;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inc;
  logic [15:0]  pending_q, pending_d;
  logic         ifid_flush, ifid_hold, ifid_load;
  if_id_t       ifid_d, ifid_q;
`ifdef FETCH_CTRL_INT_EN
  logic         int_entry;
  logic         int_ack_q;
  logic [31:0]  int_ret_q;
`endif

  assign pc_inc = pc_q + 32'd1;

  // if_id_valid=1 means decode may consume the latched word this cycle; while
  // stall is high decode sees the same record again until stall drops.
  always_comb begin
    state_d             = state_q;
    pending_d           = pending_q;
    pc_write            = 1'b0;
    pc_write_back_value = '0;
    clear_instruction   = 1'b0;
    ifid_flush          = 1'b0;
    ifid_hold           = 1'b0;
    ifid_load           = 1'b0;
    ifid_d              = '0;
`ifdef FETCH_CTRL_INT_EN
    int_entry           = 1'b0;
`endif
    if (!reset) begin
      clear_instruction = 1'b1;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          pc_write            = 1'b1;
          pc_write_back_value = BOOT_ADDR;
          clear_instruction   = 1'b1;
          ifid_flush          = 1'b1;
          state_d             = S_RUN;
        end
        S_RUN: begin
          if (branch_taken) begin
            pc_write            = 1'b1;
            pc_write_back_value = branch_target;
            clear_instruction   = 1'b1;
            ifid_flush          = 1'b1;
          end else if (stall) begin
            ifid_hold = 1'b1;
          end
`ifdef FETCH_CTRL_INT_EN
          else if (int_req) begin
            pc_write            = 1'b1;
            pc_write_back_value = INT_VECTOR;
            clear_instruction   = 1'b1;
            ifid_flush          = 1'b1;
            int_entry           = 1'b1;
          end
`endif
          else if (is_two_word(instruction, IMM_MASK)) begin
            pc_write            = 1'b1;
            pc_write_back_value = pc_inc;
            pending_d           = instruction;
            ifid_flush          = 1'b1;
            state_d             = S_IMM;
          end else begin
            pc_write            = 1'b1;
            pc_write_back_value = pc_inc;
            ifid_load           = 1'b1;
            ifid_d              = '{valid: 1'b1, instruction: instruction,
                                    immediate: 16'h0, pc_plus_one: pc_inc};
          end
        end
        S_IMM: begin
          // Interrupts wait here so a two-word instruction is never split.
          if (branch_taken) begin
            pc_write            = 1'b1;
            pc_write_back_value = branch_target;
            clear_instruction   = 1'b1;
            ifid_flush          = 1'b1;
            pending_d           = '0;
            state_d             = S_RUN;
          end else if (stall) begin
            ifid_hold = 1'b1;
          end else begin
            pc_write            = 1'b1;
            pc_write_back_value = pc_inc;
            ifid_load           = 1'b1;
            ifid_d              = '{valid: 1'b1, instruction: pending_q,
                                    immediate: immediate_value, pc_plus_one: pc_inc};
            state_d             = S_RUN;
          end
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      pc_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (pc_write) begin
        pc_q <= pc_write_back_value;
      end
    end
  end

`ifdef FETCH_CTRL_INT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_ack_q <= 1'b0;
      int_ret_q <= '0;
    end else begin
      int_ack_q <= int_entry;
      if (int_entry) begin
        int_ret_q <= pc_q;
      end
    end
  end

  assign int_ack       = int_ack_q;
  assign int_return_pc = int_ret_q;
`endif

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (reset),
    .flush (ifid_flush),
    .hold  (ifid_hold),
    .load  (ifid_load),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_valid       = ifid_q.valid;
  assign if_id_instruction = ifid_q.instruction;
  assign if_id_immediate   = ifid_q.immediate;
  assign if_id_pc_plus_one = ifid_q.pc_plus_one;
  assign state_dbg         = state_q;

endmodule
